instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Front end of the RISC-V core. Owns the fetch PC and issues in-order requests to instruction memory.
//  Returned instructions are buffered in a small FIFO. The FIFO feeds decode/datapath with {instr, pc} over valid/ready.
//  Branch/jump resolution from the datapath redirects fetch via redirect_en/redirect_pc, which flushes all younger work.
// PARAMETERS
//  WORDSIZE          64  PC / address width
//  INSTRUCTION_SIZE  32  instruction width
//  FIFO_DEPTH        4   instruction buffer entries (power of 2, >=2); also max requests in flight
//  RESET_PC          0   fetch PC loaded on reset
// PORTS
//  clk             in   1                 clock, all state updates on posedge
//  rst_n           in   1                 synchronous reset, active low
//  redirect_en     in   1                 datapath taken branch/jump this cycle
//  redirect_pc     in   WORDSIZE          new fetch target (bits [1:0] ignored)
//  imem_req_valid  out  1                 fetch request valid
//  imem_req_ready  in   1                 memory accepts request
//  imem_req_addr   out  WORDSIZE          fetch address, always 4-byte aligned
//  imem_rsp_valid  in   1                 instruction returned (in order, latency >=1, no backpressure)
//  imem_rsp_data   in   INSTRUCTION_SIZE  returned instruction
//  instr_valid     out  1                 FIFO head valid
//  instr_ready     in   1                 decode consumes head
//  instr           out  INSTRUCTION_SIZE  FIFO head instruction
//  instr_pc        out  WORDSIZE          PC of FIFO head
// BEHAVIOUR
//  State: fetch_pc, FIFO (count), in_flight (0..FIFO_DEPTH), discard_cnt (<= in_flight).
//  Reset (rst_n=0 at posedge): fetch_pc=RESET_PC; count=in_flight=discard_cnt=0; FIFO pointers=0.
//   While rst_n=0: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0. imem_req_addr=fetch_pc.
//  Reset mid-operation drops all FIFO contents and in-flight credit. Any imem_rsp_valid while in_flight==0 is ignored.
//  Credit: imem_req_valid = rst_n & (count + in_flight < FIFO_DEPTH). A FIFO slot is always free for every response.
//  req_fire = imem_req_valid & imem_req_ready. On req_fire, fetch_pc += 4 (mod 2^WORDSIZE, silent wrap).
//   Each request records its PC in order; tag FIFO or pc recomputation is an implementer choice.
//  rsp_fire = imem_rsp_valid & in_flight!=0.
//   If discard_cnt!=0, the response is dropped and discard_cnt decrements.
//   Otherwise {imem_rsp_data, pc} is enqueued.
//  in_flight_next = in_flight + req_fire - rsp_fire (both same cycle allowed).
//  Output: instr_valid = (count!=0). Head fields come straight from FIFO storage.
//   Dequeue on instr_valid & instr_ready. Head holds stable while valid & !ready.
//   Enqueue+dequeue in the same cycle leaves count unchanged.
//   Response-to-instr_valid latency: 1 cycle (registered FIFO write). No FIFO bypass.
//  Redirect (redirect_en=1 at posedge, rst_n=1):
//   fetch_pc <= {redirect_pc[WORDSIZE-1:2], 2'b00}.
//   FIFO flushed (count=0). A dequeue handshake in this cycle still counts as delivered.
//   A response arriving this cycle is not enqueued.
//   discard_cnt <= in_flight_next. Every outstanding request, including one accepted this cycle, returns and is dropped.
//   imem_req_addr in the redirect cycle is the old fetch_pc. Its request, if accepted, is discarded as above.
//   Back-to-back redirects: the latest wins and discard_cnt is recomputed each time.
//  Priority: rst_n > redirect_en > normal operation.
//  Steady state with 1-cycle memory and instr_ready=1: one instruction per cycle.
// TESTING
//  T1 reset, mem latency 1, req_ready=1, instr_ready=1 -> instr_pc 0x0,0x4,0x8,... one per cycle, data matches mem[pc>>2].
//  T2 instr_ready=0 -> exactly FIFO_DEPTH reqs (0x0..0xC) then req_valid=0. Release -> next req addr 0x10, order intact.
//  T3 mem latency 3, 2 requests in flight, redirect_pc=0x100 -> both responses dropped, first instr_pc=0x100.
//  T4 redirect_pc=0x103 -> imem_req_addr=0x100. Redirect coincident with req_fire and rsp_fire -> neither stale instr appears.
//  T5 redirect_pc=0xFFFF_FFFF_FFFF_FFFC -> instr_pc ...FFFC then 0x0 (wrap).
//  T6 rst_n=0 for 1 cycle with 3 in flight, then stale responses -> ignored; first instr_pc=RESET_PC, instr_valid=0 during reset.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited in-order imem requests,
// and buffers returned instructions with their PCs for decode.
module instruction_fetch_unit #(
    parameter int unsigned         WORDSIZE         = 64,
    parameter int unsigned         INSTRUCTION_SIZE = 32,
    parameter int unsigned         FIFO_DEPTH       = 4,
    parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        redirect_en,
    input  logic [WORDSIZE-1:0]         redirect_pc,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [WORDSIZE-1:0]         imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [INSTRUCTION_SIZE-1:0] imem_rsp_data,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [INSTRUCTION_SIZE-1:0] instr,
    output logic [WORDSIZE-1:0]         instr_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [WORDSIZE-1:0]         fetch_pc;
    logic [CNT_W-1:0]            count;
    logic [CNT_W-1:0]            in_flight;
    logic [CNT_W-1:0]            in_flight_next;
    logic [CNT_W-1:0]            discard_cnt;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [INSTRUCTION_SIZE-1:0] data_mem [FIFO_DEPTH];
    logic [WORDSIZE-1:0]         pc_mem   [FIFO_DEPTH];

    logic                        credit_ok;
    logic                        req_fire;
    logic                        rsp_fire;
    logic                        enq;
    logic                        deq;
    logic [WORDSIZE-1:0]         rsp_pc;

    // Buffered plus outstanding never exceeds depth, so every response has a slot.
    assign credit_ok      = ({1'b0, count} + {1'b0, in_flight}) < SUM_W'(FIFO_DEPTH);
    assign imem_req_valid = rst_n & credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_fire       = imem_rsp_valid & (in_flight != '0);
    assign enq            = rst_n & ~redirect_en & rsp_fire & (discard_cnt == '0);
    assign deq            = instr_valid & instr_ready;
    assign in_flight_next = in_flight + CNT_W'(req_fire) - CNT_W'(rsp_fire);

    // Responses return in order, so the oldest outstanding request sits in_flight words behind fetch_pc.
    assign rsp_pc = fetch_pc - (WORDSIZE'(in_flight) << 2);

    assign instr_valid = rst_n & (count != '0);
    assign instr       = rst_n ? data_mem[rd_ptr] : '0;
    assign instr_pc    = rst_n ? pc_mem[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            in_flight   <= '0;
            discard_cnt <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_en) begin
            // Everything still outstanding, including a request accepted now, comes back stale.
            fetch_pc    <= redirect_pc & ~WORDSIZE'(3);
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_flight   <= in_flight_next;
            discard_cnt <= in_flight_next;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + WORDSIZE'(4);
            end
            in_flight <= in_flight_next;
            if (rsp_fire && (discard_cnt != '0)) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order variable-latency memory model, delivery/request logs,
// a redirect vector table and hand-written reset/backpressure sequences.
module tb_instruction_fetch_unit;

    localparam logic [31:0] DATA_KEY = 32'h1357_9BDF;

    logic        clk;
    logic        rst_n;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    instruction_fetch_unit #(
        .WORDSIZE(64), .INSTRUCTION_SIZE(32), .FIFO_DEPTH(4), .RESET_PC(64'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } dlv_t;

    typedef struct {
        int          lat;
        int          pre;
        logic        rdy;
        logic [63:0] target;
        logic [63:0] exp_pc;
    } vec_t;

    mreq_t       mq[$];
    dlv_t        dq[$];
    logic [63:0] rq[$];
    int          cyc = 0;
    int          mem_lat = 1;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        vecs[4];

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        return 32'(addr >> 2) ^ DATA_KEY;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: presents due responses at negedge, logs accepted requests just after.
    always @(negedge clk) begin
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            rq.push_back(imem_req_addr);
        end
        if (rst_n && instr_valid && instr_ready) begin
            dq.push_back('{pc: instr_pc, data: instr});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        redirect_en    = 1'b0;
        repeat (5) @(negedge clk);
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_instr_pc", instr_pc, 64'd0);
        check("rst_req_addr", imem_req_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_dq(input string name, input int n, input logic [63:0] first_pc);
        logic [63:0] pc;
        check({name, "_count"}, 64'(dq.size() >= n), 64'd1);
        pc = first_pc;
        for (int i = 0; i < n && i < dq.size(); i++) begin
            check($sformatf("%s_pc%0d", name, i), dq[i].pc, pc);
            check($sformatf("%s_data%0d", name, i), 64'(dq[i].data), 64'(mem_word(pc)));
            pc = pc + 64'd4;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_en    = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        vecs[0] = '{lat: 3, pre: 2, rdy: 1'b0, target: 64'h100, exp_pc: 64'h100};
        vecs[1] = '{lat: 1, pre: 3, rdy: 1'b1, target: 64'h103, exp_pc: 64'h100};
        vecs[2] = '{lat: 2, pre: 4, rdy: 1'b1, target: 64'h2002, exp_pc: 64'h2000};
        vecs[3] = '{lat: 1, pre: 2, rdy: 1'b1, target: 64'hFFFF_FFFF_FFFF_FFFC,
                    exp_pc: 64'hFFFF_FFFF_FFFF_FFFC};

        // Steady stream at latency 1: first delivery two cycles after release, then one per cycle.
        do_reset();
        mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        dq.delete(); rq.delete();
        repeat (20) @(negedge clk);
        check("t1_throughput", 64'(dq.size()), 64'd18);
        check_dq("t1", 12, 64'h0);

        // Decode stalled: credit caps requests at the buffer depth.
        do_reset();
        mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        dq.delete(); rq.delete();
        repeat (10) @(negedge clk);
        check("t2_req_count", 64'(rq.size()), 64'd4);
        for (int i = 0; i < 4 && i < rq.size(); i++)
            check($sformatf("t2_req%0d", i), rq[i], 64'(4 * i));
        check("t2_req_valid_held", 64'(imem_req_valid), 64'd0);
        check("t2_head_valid", 64'(instr_valid), 64'd1);
        check("t2_head_pc", instr_pc, 64'h0);
        instr_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("t2_req_count2", 64'(rq.size() >= 5), 64'd1);
        if (rq.size() >= 5) check("t2_req4", rq[4], 64'h10);
        check_dq("t2", 6, 64'h0);

        // Redirect vectors: varied latency, in-flight depth and coincident handshakes.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            mem_lat = vecs[v].lat; imem_req_ready = 1'b1; instr_ready = 1'b1;
            repeat (vecs[v].pre) @(negedge clk);
            redirect_en    = 1'b1;
            redirect_pc    = vecs[v].target;
            imem_req_ready = vecs[v].rdy;
            @(negedge clk);
            redirect_en    = 1'b0;
            imem_req_ready = 1'b1;
            dq.delete(); rq.delete();
            repeat (15) @(negedge clk);
            check($sformatf("v%0d_req_seen", v), 64'(rq.size() > 0), 64'd1);
            if (rq.size() > 0) check($sformatf("v%0d_req0", v), rq[0], vecs[v].exp_pc);
            check_dq($sformatf("v%0d", v), 2, vecs[v].exp_pc);
        end

        // Mid-operation reset with three requests outstanding and a buffered instruction.
        do_reset();
        mem_lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(instr_valid), 64'd0);
        check("t6_rst_instr", 64'(instr), 64'd0);
        check("t6_rst_pc", instr_pc, 64'd0);
        check("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; imem_req_ready = 1'b0; instr_ready = 1'b1;
        dq.delete(); rq.delete();
        #1;
        check("t6_post_valid", 64'(instr_valid), 64'd0);
        check("t6_post_addr", imem_req_addr, 64'h0);
        repeat (3) @(negedge clk);
        check("t6_no_stale", 64'(dq.size()), 64'd0);
        imem_req_ready = 1'b1;
        repeat (12) @(negedge clk);
        check_dq("t6", 3, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
